// File: rtl/membus_ctrl.sv
// Bus slave for the 6502 board: internal RAM, IO window, wait states.
// Completion, timeout and unmapped errors are reported via done/bus_err.
module membus_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RAM_DEPTH  = 16384,
    parameter int RAM_WAIT   = 0,
    parameter int IO_BASE    = 'hD000,
    parameter int IO_CH      = 4,
    parameter int IO_SPAN    = 16,
    parameter int IO_WAIT    = 2,
    parameter int IO_TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       req,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       rw,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       done,
    output logic                       bus_err,
    output logic                       busy,
    output logic [IO_CH-1:0]           io_sel,
    output logic [$clog2(IO_SPAN)-1:0] io_addr,
    output logic                       io_rw,
    output logic [DATA_W-1:0]          io_wdata,
    input  logic [IO_CH*DATA_W-1:0]    io_rdata,
    input  logic [IO_CH-1:0]           io_ack
);

    localparam int OFF_W  = $clog2(IO_SPAN);
    localparam int CH_W   = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int TO_W   = $clog2(IO_TIMEOUT + 1);
    localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [ADDR_W:0] IO_LO   = (ADDR_W+1)'(IO_BASE);
    localparam logic [ADDR_W:0] IO_HI   = (ADDR_W+1)'(IO_BASE + IO_CH * IO_SPAN);

    typedef enum logic [2:0] {IDLE, RWAIT, IOWAIT, IOACK, ERR} state_t;

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [IO_CH-1:0]    io_sel_q, io_sel_d;
    logic [OFF_W-1:0]    io_addr_q, io_addr_d;
    logic                io_rw_q, io_rw_d;
    logic [DATA_W-1:0]   io_wdata_q, io_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                bus_err_q, bus_err_d;

    logic [DATA_W-1:0]   mem [RAM_DEPTH];
    logic [ADDR_W:0]     addr_x, off;
    logic [CH_W-1:0]     ch_sel;
    logic                is_ram, is_io, ack_hit, timeout, fin, ram_we;
    logic [DATA_W-1:0]   ch_rdata;
    logic                unused_bits;

    assign addr_x      = {1'b0, addr};
    assign off         = addr_x - IO_LO;
    assign ch_sel      = off[OFF_W +: CH_W];
    assign unused_bits = ^off;
    assign is_ram      = addr_x < RAM_END;
    assign is_io       = (addr_x >= IO_LO) && (addr_x < IO_HI);
    assign ack_hit     = io_ack[ch_q];
    assign ch_rdata    = io_rdata[int'(ch_q) * DATA_W +: DATA_W];
    assign timeout     = tcnt_q == TO_W'(IO_TIMEOUT - 1);

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        ram_addr_d = ram_addr_q;
        ch_d       = ch_q;
        io_sel_d   = io_sel_q;
        io_addr_d  = io_addr_q;
        io_rw_d    = io_rw_q;
        io_wdata_d = io_wdata_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        ram_we     = 1'b0;
        fin        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    ram_addr_d = addr[RAM_AW-1:0];
                    io_rw_d    = rw;
                    io_wdata_d = wdata;
                    ch_d       = ch_sel;
                    tcnt_d     = '0;
                    if (is_ram) begin
                        state_d = RWAIT;
                        wcnt_d  = 4'(RAM_WAIT);
                    end else if (is_io) begin
                        io_sel_d  = IO_CH'(1) << ch_sel;
                        io_addr_d = off[OFF_W-1:0];
                        if (IO_WAIT == 0) begin
                            state_d = IOACK;
                        end else begin
                            state_d = IOWAIT;
                            wcnt_d  = 4'(IO_WAIT - 1);
                        end
                    end else begin
                        // two-cycle error path keeps decode off the done timing
                        state_d = ERR;
                        wcnt_d  = 4'd1;
                    end
                end
            end
            RWAIT: begin
                if (wcnt_q == 4'd0) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                    if (io_rw_q) rdata_d = mem[ram_addr_q];
                    else         ram_we  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            IOWAIT: begin
                tcnt_d = tcnt_q + TO_W'(1);
                if (wcnt_q == 4'd0) state_d = IOACK;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            IOACK: begin
                tcnt_d = tcnt_q + TO_W'(1);
                if (ack_hit) begin
                    fin      = 1'b1;
                    state_d  = IDLE;
                    io_sel_d = '0;
                    if (io_rw_q) rdata_d = ch_rdata;
                end else if (timeout) begin
                    fin       = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    io_sel_d  = '0;
                    rdata_d   = '1;
                end
            end
            ERR: begin
                if (wcnt_q == 4'd0) begin
                    fin       = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    rdata_d   = '1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = fin;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            tcnt_q     <= '0;
            ram_addr_q <= '0;
            ch_q       <= '0;
            io_sel_q   <= '0;
            io_addr_q  <= '0;
            io_rw_q    <= 1'b0;
            io_wdata_q <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            ram_addr_q <= ram_addr_d;
            ch_q       <= ch_d;
            io_sel_q   <= io_sel_d;
            io_addr_q  <= io_addr_d;
            io_rw_q    <= io_rw_d;
            io_wdata_q <= io_wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // RAM survives reset; a write caught by clr is dropped
    always_ff @(posedge clk) begin
        if (ram_we && !clr) mem[ram_addr_q] <= io_wdata_q;
    end

    assign busy     = (state_q != IDLE) && !fin;
    assign rdata    = rdata_q;
    assign done     = done_q;
    assign bus_err  = bus_err_q;
    assign io_sel   = io_sel_q;
    assign io_addr  = io_addr_q;
    assign io_rw    = io_rw_q;
    assign io_wdata = io_wdata_q;

endmodule

// File: tb/tb_membus_ctrl.sv
// Scoreboard bench for membus_ctrl: instance a has RAM_WAIT=0,
// instance b has RAM_WAIT=2; a monitor checks every done pulse.
module tb_membus_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] rd;
        logic       er;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    int          cyc = 0;
    int          nvec = 0;
    int          nfail = 0;
    exp_t        qa[$];
    exp_t        qb[$];

    logic        a_req, a_rw, a_done, a_bus_err, a_busy, a_io_rw;
    logic [15:0] a_addr;
    logic [7:0]  a_wdata, a_rdata, a_io_wdata;
    logic [3:0]  a_io_sel, a_io_addr, a_io_ack;
    logic [31:0] a_io_rdata;

    logic        b_req, b_rw, b_done, b_bus_err, b_busy, b_io_rw;
    logic [15:0] b_addr;
    logic [7:0]  b_wdata, b_rdata, b_io_wdata;
    logic [3:0]  b_io_sel, b_io_addr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    membus_ctrl #(.RAM_WAIT(0)) u_a (
        .clk(clk), .clr(clr), .req(a_req), .addr(a_addr), .rw(a_rw),
        .wdata(a_wdata), .rdata(a_rdata), .done(a_done),
        .bus_err(a_bus_err), .busy(a_busy), .io_sel(a_io_sel),
        .io_addr(a_io_addr), .io_rw(a_io_rw), .io_wdata(a_io_wdata),
        .io_rdata(a_io_rdata), .io_ack(a_io_ack)
    );

    membus_ctrl #(.RAM_WAIT(2)) u_b (
        .clk(clk), .clr(clr), .req(b_req), .addr(b_addr), .rw(b_rw),
        .wdata(b_wdata), .rdata(b_rdata), .done(b_done),
        .bus_err(b_bus_err), .busy(b_busy), .io_sel(b_io_sel),
        .io_addr(b_io_addr), .io_rw(b_io_rw), .io_wdata(b_io_wdata),
        .io_rdata(32'h0), .io_ack(4'h0)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // drive one request for one cycle; returns in the cycle after accept
    task automatic issue(input bit b, input logic [15:0] ad,
                         input logic r, input logic [7:0] wd,
                         input int lat, input logic [7:0] rd,
                         input logic er, input bit push);
        exp_t e;
        e.cyc = cyc + 1 + lat;
        e.rd  = rd;
        e.er  = er;
        if (b) begin
            b_req = 1'b1; b_addr = ad; b_rw = r; b_wdata = wd;
            if (push) qb.push_back(e);
        end else begin
            a_req = 1'b1; a_addr = ad; a_rw = r; a_wdata = wd;
            if (push) qa.push_back(e);
        end
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_done) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 32'(a_done), 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_done_cycle", 32'(cyc), 32'(e.cyc));
                chk("a_rdata", 32'(a_rdata), 32'(e.rd));
                chk("a_bus_err", 32'(a_bus_err), 32'(e.er));
            end
        end else if (a_bus_err) begin
            chk("a_err_without_done", 32'(a_bus_err), 32'd0);
        end
        if (b_done) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 32'(b_done), 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_done_cycle", 32'(cyc), 32'(e.cyc));
                chk("b_rdata", 32'(b_rdata), 32'(e.rd));
                chk("b_bus_err", 32'(b_bus_err), 32'(e.er));
            end
        end else if (b_bus_err) begin
            chk("b_err_without_done", 32'(b_bus_err), 32'd0);
        end
    end

    initial begin
        clr = 1'b1;
        a_req = 0; a_rw = 0; a_addr = 0; a_wdata = 0;
        a_io_ack = 4'h0;
        a_io_rdata = 32'hC3_5A_11_07;
        b_req = 0; b_rw = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", 32'(a_rdata), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_done", 32'(a_done), 32'h0);
        chk("rst_io_sel", 32'(a_io_sel), 32'h0);
        chk("rst_io_rw", 32'(a_io_rw), 32'h0);
        clr = 1'b0;

        // RAM, zero wait: write, back-to-back read, preload 0x0000
        issue(0, 16'h2223, 0, 8'h44, 1, 8'h00, 0, 1);
        chk("t1_busy_w", 32'(a_busy), 32'h0);
        @(negedge clk);
        issue(0, 16'h2223, 1, 8'h00, 1, 8'h44, 0, 1);
        chk("t1_busy_r", 32'(a_busy), 32'h0);
        @(negedge clk);
        issue(0, 16'h0000, 0, 8'h33, 1, 8'h44, 0, 1);
        @(negedge clk);

        // unmapped read and write; RAM word 0 must be untouched
        issue(0, 16'h8000, 1, 8'h00, 2, 8'hFF, 1, 1);
        chk("t5_busy", 32'(a_busy), 32'h1);
        repeat (2) @(negedge clk);
        issue(0, 16'h8000, 0, 8'h12, 2, 8'hFF, 1, 1);
        repeat (2) @(negedge clk);
        issue(0, 16'h0000, 1, 8'h00, 1, 8'h33, 0, 1);
        @(negedge clk);

        // IO read ch2: early ack, wrong-channel ack, then honoured ack
        issue(0, 16'hD025, 1, 8'h00, 4, 8'h5A, 0, 1);
        chk("t3_io_sel", 32'(a_io_sel), 32'h4);
        chk("t3_io_addr", 32'(a_io_addr), 32'h5);
        chk("t3_io_rw", 32'(a_io_rw), 32'h1);
        chk("t3_busy", 32'(a_busy), 32'h1);
        @(negedge clk); a_io_ack = 4'b0100;
        @(negedge clk); a_io_ack = 4'b0010;
        @(negedge clk); a_io_ack = 4'b0110;
        @(negedge clk); a_io_ack = 4'b0000;
        chk("t3_io_sel_clr", 32'(a_io_sel), 32'h0);
        chk("t3_busy_end", 32'(a_busy), 32'h0);
        @(negedge clk);

        // IO write ch3 with no ack: timeout
        issue(0, 16'hD030, 0, 8'hA7, 32, 8'hFF, 1, 1);
        chk("t4_io_sel", 32'(a_io_sel), 32'h8);
        chk("t4_io_wdata", 32'(a_io_wdata), 32'hA7);
        chk("t4_io_rw", 32'(a_io_rw), 32'h0);
        repeat (30) @(negedge clk);
        chk("t4_busy_late", 32'(a_busy), 32'h1);
        chk("t4_io_sel_late", 32'(a_io_sel), 32'h8);
        repeat (2) @(negedge clk);
        chk("t4_io_sel_clr", 32'(a_io_sel), 32'h0);
        @(negedge clk);

        // RAM_WAIT=2: preload, read, ignored req while busy
        issue(1, 16'h0100, 0, 8'hEE, 3, 8'h00, 0, 1);
        repeat (3) @(negedge clk);
        issue(1, 16'h0100, 1, 8'h00, 3, 8'hEE, 0, 1);
        chk("t2_busy0", 32'(b_busy), 32'h1);
        b_req = 1'b1; b_addr = 16'h0200; b_rw = 1'b1;
        @(negedge clk);
        chk("t2_busy1", 32'(b_busy), 32'h1);
        b_req = 1'b0;
        @(negedge clk);
        chk("t2_busy2", 32'(b_busy), 32'h0);
        repeat (2) @(negedge clk);
        chk("t2_no_extra_done", 32'(b_done), 32'h0);

        // reset mid-access: IO on a, pending RAM write on b
        issue(0, 16'hD000, 1, 8'h00, 0, 8'h00, 0, 0);
        chk("t6_io_sel", 32'(a_io_sel), 32'h1);
        issue(1, 16'h0100, 0, 8'h99, 0, 8'h00, 0, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t6_io_sel_clr", 32'(a_io_sel), 32'h0);
        chk("t6_busy", 32'(a_busy), 32'h0);
        chk("t6_done", 32'(a_done), 32'h0);
        chk("t6_rdata", 32'(a_rdata), 32'h0);
        chk("t6_b_busy", 32'(b_busy), 32'h0);
        issue(0, 16'h2223, 1, 8'h00, 1, 8'h44, 0, 1);
        issue(1, 16'h0100, 1, 8'h00, 3, 8'hEE, 0, 1);
        repeat (6) @(negedge clk);

        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/membus_ctrl.md
Name: membus_ctrl

Overview:
Parametrised memory/bus subsystem for the 6502 board. It replaces the bare single-cycle RAM hookup with one bus slave. The slave holds internal RAM, decodes a memory-mapped I/O window into IO_CH peripheral channels, inserts per-region wait states, and reports completion, timeout and unmapped-access errors back to the CPU-side sequencer. It sits between the address bus registers, the data output register and the peripherals.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
RAM_DEPTH, 16384, internal RAM words at addresses 0..RAM_DEPTH-1; must be ≤ 2^ADDR_W
RAM_WAIT, 0, extra wait cycles for RAM accesses (0..15)
IO_BASE, 'hD000, base address of the I/O window; must be ≥ RAM_DEPTH
IO_CH, 4, number of I/O channels (1..16)
IO_SPAN, 16, addresses per channel; power of 2
IO_WAIT, 2, minimum cycles before io_ack is honoured (0..15)
IO_TIMEOUT, 32, cycles after io_sel assertion before the access is aborted; must be > IO_WAIT

Ports:
clk  in  1  system clock; all state changes on rising edge
clr  in  1  synchronous active-high reset
req  in  1  bus cycle request; sampled only when busy=0
addr  in  ADDR_W  access address
rw  in  1  1 = read, 0 = write
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data; valid while done=1, held until next done
done  out  1  one-cycle completion pulse
bus_err  out  1  one-cycle pulse coincident with done on an error completion
busy  out  1  access in flight; drives the CPU's ready/stall
io_sel  out  IO_CH  one-hot channel select
io_addr  out  log2(IO_SPAN)  offset within the channel
io_rw  out  1  copy of the latched rw
io_wdata  out  DATA_W  latched write data
io_rdata  in  IO_CH*DATA_W  per-channel read data; channel k occupies bits [k*DATA_W +: DATA_W]
io_ack  in  IO_CH  per-channel completion

Behaviour:
- Reset (clr=1 at an edge): state IDLE; done, bus_err, busy, io_sel, io_rw, io_addr, io_wdata and rdata all go to 0; wait and timeout counters are cleared. RAM contents are preserved. Reset mid-access aborts it with no done, and a pending RAM write is not performed.
- Accept: at an edge with state IDLE and req=1, latch addr, rw and wdata, then decode:
  - RAM: addr < RAM_DEPTH.
  - IO: IO_BASE ≤ addr < IO_BASE + IO_CH*IO_SPAN. Channel = (addr-IO_BASE)/IO_SPAN; offset = the low bits.
  - Anything else is unmapped.
- While busy=1, req is ignored and is not queued. busy is high from the cycle after acceptance up to, but not including, the done cycle.
- FSM states: IDLE, RWAIT, IOWAIT, IOACK, ERR.
  - RAM path: IDLE→RWAIT with counter = RAM_WAIT. The RAM access occurs at the edge where the counter is 0; the counter decrements otherwise. At that edge the write updates memory, or the read loads rdata; done then pulses and the FSM returns to IDLE. done is asserted RAM_WAIT+1 cycles after the accept edge. With RAM_WAIT=0, busy never rises.
  - Back-to-back accesses: a new req may be accepted in the done cycle, since the state is IDLE.
  - IO path: IDLE→IOWAIT. io_sel, io_addr, io_rw and io_wdata are driven from the cycle after acceptance and held until completion. After IO_WAIT cycles the FSM enters IOACK.
  - io_ack of the selected channel is honoured only in IOACK; acks from other channels are ignored.
  - On honoured ack: rdata takes that channel's io_rdata slice on a read, or is left unchanged on a write. done pulses next cycle and io_sel clears in the same cycle.
  - Timeout counter starts when io_sel asserts. If it reaches IO_TIMEOUT with no honoured ack, io_sel clears, rdata = all ones, done and bus_err pulse, and the FSM returns to IDLE. If ack and timeout occur on the same edge, ack wins.
  - Unmapped: IDLE→ERR for one cycle, then done + bus_err with rdata = all ones. Writes are discarded.
- rdata is updated only on read completions and error completions.

Test Plan:
1. RAM_WAIT=0: write 0x44 to 0x2223, then read 0x2223 → done 1 cycle after each accept, busy stays 0, rdata=0x44, bus_err=0.
2. RAM_WAIT=2: read 0x0100 preloaded with 0xEE → busy high 2 cycles, done on the 3rd cycle after accept, rdata=0xEE. A second req issued during busy is ignored, with no extra done.
3. IO read at 0xD025 (IO_SPAN=16): io_sel=4'b0100 and io_addr=5. Channel 2 raises ack 1 cycle after io_sel with IO_WAIT=2 → ack ignored, held ack honoured → rdata = ch2 slice (0x5A), done 1 cycle after the honoured ack.
4. IO write at 0xD030 with no ack → after IO_TIMEOUT=32 cycles, done=1, bus_err=1, rdata=0xFF, io_sel=0.
5. Read of unmapped 0x8000 (RAM_DEPTH=16384) → done 2 cycles after accept, bus_err=1, rdata=0xFF. Write to 0x8000 → no RAM change.
6. clr pulsed during IOWAIT → next cycle: io_sel=0, busy=0, no done. The previously written RAM at 0x2223 still reads 0x44.
